alarm_msg_scheduler: RTL and testbench
======================================

// Module: alarm_msg_scheduler
// PURPOSE
// - Arbitrates four colour-coded alarm requests (RED, BLUE, PURPLE, YELLOW) for the single shared text_reader
//   (tick timer + address counter + four morse ROMs).
// - Restarts the reader per message, paces it and routes the winning colour's ROM byte to char_out.
// - Acks each request when its message completes. Sits between the alarm input logic and the morse/display output stage.
// PARAMETERS
// - GAP_CYCLES  1000  idle clk cycles enforced after a message before the next arbitration (>=1)
// - TERM_CHAR   8'h00 ROM byte that ends a message early; it is not emitted
// PORTS
// - clk         in   1  system clock, all logic rising-edge
// - reset_n     in   1  asynchronous active-low reset
// - req         in   4  alarm requests [0]=RED [1]=BLUE [2]=PURPLE [3]=YELLOW; pulse or level
// - rd_tick     in   1  reader tick (text_reader done_w)
// - rd_done     in   1  reader address counter at final value (text_reader done_text)
// - rom_r/b/p/y in   8  each  reader ROM outputs per colour
// - rd_en       out  1  reader timer enable
// - rd_clr_n    out  1  registered active-low reader restart, ANDed with reset_n outside this block
// - char_out    out  8  current message character
// - char_valid  out  1  one-cycle strobe, char_out valid
// - active_id   out  2  colour being played (encoding as req index)
// - busy        out  1  high in CLEAR/PLAY
// - ack         out  4  one-cycle pulse on the completed colour
// BEHAVIOUR
// - Reset values: rd_en=0, rd_clr_n=1, char_out=0, char_valid=0, active_id=0, busy=0, ack=0, pending=0, state=IDLE.
// - pending[i] is set on any cycle req[i]=1 and cleared on ack[i]. If set and clear coincide, set wins (message replays).
// - Priority is fixed: RED > BLUE > PURPLE > YELLOW.
// - IDLE: if pending!=0, latch active_id = highest pending, go to CLEAR.
// - CLEAR (exactly 1 cycle): rd_clr_n=0, rd_en=0, busy=1, then go to PLAY.
// - PLAY: rd_en=1, busy=1. On rd_tick, sample ROM[active_id] as byte b (address not yet advanced):
//   - if b==TERM_CHAR: no strobe, go to DONE;
//   - else next cycle char_out=b and char_valid=1;
//   - if rd_done was also high with that tick, emit b, then go to DONE.
// - First emitted character is from address 0; latency is rd_tick -> char_valid = 1 cycle.
// - DONE (1 cycle): rd_en=0, busy=0, ack[active_id]=1, pending[active_id] cleared, go to GAP.
// - GAP: count GAP_CYCLES cycles with rd_en=0, then go to IDLE. req is still latched during GAP.
// - rd_tick outside PLAY is ignored. char_out holds its last value between strobes.
// - Reset asserted mid-message: immediate return to the reset values; nothing is acked.
// CONFIGURATION
// - ALARM_PREEMPT_EN defined: in PLAY, if a higher-priority pending bit is set, abort at the next clk.
//   - The aborted colour gets no ack and stays pending.
//   - active_id takes the new winner and the FSM goes straight to CLEAR (no GAP).
//   - Equal or lower priority never preempts.
// - ALARM_PREEMPT_EN undefined: the message always runs to DONE; new requests only latch.
// STRUCTURE
// - Shared package alarm_pkg:
//   - colour index constants CH_RED=0, CH_BLUE=1, CH_PURPLE=2, CH_YELLOW=3;
//   - FSM state encoding IDLE/CLEAR/PLAY/DONE/GAP;
//   - default TERM_CHAR.
// - Sub-module prio_enc4: combinational 4-bit fixed-priority encoder (valid + 2-bit index).
//   Used for arbitration and, under ALARM_PREEMPT_EN, for the preempt compare.
// - GAP counter width is $clog2(GAP_CYCLES+1).
// TESTING
// - Bench uses a behavioural reader model with a 4-cycle tick and ROMs preloaded "SOS" then 8'h00.
// - Reset, then req=4'b0001 pulse: CLEAR pulse, 3 strobes 'S','O','S', TERM stop, ack=4'b0001,
//   then GAP_CYCLES idle with rd_en=0.
// - req=4'b1010 same cycle: BLUE plays first and acks; after GAP, YELLOW plays and acks; no char mixing.
// - ROM without TERM_CHAR: rd_done with the tick at address 254 emits the last byte, then ack.
// - YELLOW playing, RED request arrives: no preempt build -> YELLOW completes then RED;
//   ALARM_PREEMPT_EN -> next cycle CLEAR with active_id=0, YELLOW acked only later.
// - reset_n low mid-PLAY: all outputs at reset values the same cycle, pending=0, no ack after release.
// - req[0] held high through its own ack: message replays after GAP.

Source files
------------

// File: rtl/alarm_pkg.sv
// -----------------------------------------------------------------------------
// alarm_pkg
// Shared definitions for the alarm message scheduler.
//   - Colour indices; the request, ack and active_id encodings all use them.
//   - FSM state encoding of the scheduler.
//   - Default message terminator byte.
// -----------------------------------------------------------------------------
package alarm_pkg;

    // Colour index constants (also the fixed priority order, 0 = highest)
    localparam logic [1:0] CH_RED    = 2'd0;
    localparam logic [1:0] CH_BLUE   = 2'd1;
    localparam logic [1:0] CH_PURPLE = 2'd2;
    localparam logic [1:0] CH_YELLOW = 2'd3;

    // Scheduler FSM states
    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_CLEAR = 3'd1;
    localparam logic [2:0] ST_PLAY  = 3'd2;
    localparam logic [2:0] ST_DONE  = 3'd3;
    localparam logic [2:0] ST_GAP   = 3'd4;

    // ROM byte that ends a message early (never emitted)
    localparam logic [7:0] TERM_CHAR_DEFAULT = 8'h00;

endpackage

// File: rtl/prio_enc4.sv
// -----------------------------------------------------------------------------
// prio_enc4
// Combinational 4-bit fixed-priority encoder, bit 0 (RED) wins.
// Ports:
//   req_i   in  4  request vector, indexed by colour
//   valid_o out 1  any request bit set
//   idx_o   out 2  index of the highest-priority set bit (CH_RED when none)
// -----------------------------------------------------------------------------
module prio_enc4
    import alarm_pkg::*;
(
    input  logic [3:0] req_i,
    output logic       valid_o,
    output logic [1:0] idx_o
);

    always_comb begin
        valid_o = 1'b1;
        idx_o   = CH_RED;
        if (req_i[CH_RED]) begin
            idx_o = CH_RED;
        end else if (req_i[CH_BLUE]) begin
            idx_o = CH_BLUE;
        end else if (req_i[CH_PURPLE]) begin
            idx_o = CH_PURPLE;
        end else if (req_i[CH_YELLOW]) begin
            idx_o = CH_YELLOW;
        end else begin
            valid_o = 1'b0;
        end
    end

endmodule

// File: rtl/alarm_msg_scheduler.sv
// -----------------------------------------------------------------------------
// alarm_msg_scheduler
// Arbitrates four colour alarm requests for one shared text reader, restarts
// and paces the reader per message, routes the winning colour's ROM byte to
// char_out_o and acks the colour when its message completes.
//
// Build option: define ALARM_PREEMPT_EN to let a higher-priority pending
// request abort the message being played (no ack, stays pending, straight to
// CLEAR). Undefined: every message runs to completion.
//
// Parameters:
//   GAP_CYCLES  idle cycles after each message before the next arbitration (>=1)
//   TERM_CHAR   ROM byte that ends a message early, not emitted
// Ports:
//   clk           in   1  clock, rising edge
//   reset_n       in   1  asynchronous active-low reset
//   req_i         in   4  alarm requests [0]=RED [1]=BLUE [2]=PURPLE [3]=YELLOW
//   rd_tick_i     in   1  reader tick
//   rd_done_i     in   1  reader address counter at its final value
//   rom_r/b/p/y_i in   8  reader ROM outputs per colour
//   rd_en_o       out  1  reader timer enable (PLAY)
//   rd_clr_n_o    out  1  registered active-low reader restart (CLEAR)
//   char_out_o    out  8  current message character, holds between strobes
//   char_valid_o  out  1  one-cycle strobe for char_out_o
//   active_id_o   out  2  colour being played
//   busy_o        out  1  high in CLEAR/PLAY
//   ack_o         out  4  one-cycle pulse on the completed colour
// -----------------------------------------------------------------------------
module alarm_msg_scheduler
    import alarm_pkg::*;
#(
    parameter int unsigned GAP_CYCLES = 1000,
    parameter logic [7:0]  TERM_CHAR  = TERM_CHAR_DEFAULT
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [3:0] req_i,
    input  logic       rd_tick_i,
    input  logic       rd_done_i,
    input  logic [7:0] rom_r_i,
    input  logic [7:0] rom_b_i,
    input  logic [7:0] rom_p_i,
    input  logic [7:0] rom_y_i,
    output logic       rd_en_o,
    output logic       rd_clr_n_o,
    output logic [7:0] char_out_o,
    output logic       char_valid_o,
    output logic [1:0] active_id_o,
    output logic       busy_o,
    output logic [3:0] ack_o
);

    localparam int GW = $clog2(GAP_CYCLES + 1);
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);

    logic [2:0]    state_q, state_d;
    logic [3:0]    pending_q, pending_d;
    logic [1:0]    active_id_q, active_id_d;
    logic [7:0]    char_out_q, char_out_d;
    logic          char_valid_q, char_valid_d;
    logic          rd_clr_n_q, rd_clr_n_d;
    logic [GW-1:0] gap_cnt_q, gap_cnt_d;

    logic          arb_valid;
    logic [1:0]    arb_idx;
    logic          preempt;
    logic [1:0]    pre_idx;
    logic [7:0]    rom_byte;
    logic [3:0]    ack_w;

    prio_enc4 u_arb (
        .req_i   (pending_q),
        .valid_o (arb_valid),
        .idx_o   (arb_idx)
    );

`ifdef ALARM_PREEMPT_EN
    // Only colours strictly above the active one may abort it.
    logic [3:0] higher_pend;
    assign higher_pend = pending_q & ((4'b0001 << active_id_q) - 4'b0001);

    prio_enc4 u_pre (
        .req_i   (higher_pend),
        .valid_o (preempt),
        .idx_o   (pre_idx)
    );
`else
    assign preempt = 1'b0;
    assign pre_idx = CH_RED;
`endif

    always_comb begin
        case (active_id_q)
            CH_RED:    rom_byte = rom_r_i;
            CH_BLUE:   rom_byte = rom_b_i;
            CH_PURPLE: rom_byte = rom_p_i;
            default:   rom_byte = rom_y_i;
        endcase
    end

    assign ack_w = (state_q == ST_DONE) ? (4'b0001 << active_id_q) : 4'b0000;

    always_comb begin
        state_d      = state_q;
        active_id_d  = active_id_q;
        char_out_d   = char_out_q;
        char_valid_d = 1'b0;
        gap_cnt_d    = gap_cnt_q;
        // A request arriving on the ack cycle re-arms the colour (replay).
        pending_d    = (pending_q & ~ack_w) | req_i;

        case (state_q)
            ST_IDLE: begin
                if (arb_valid) begin
                    active_id_d = arb_idx;
                    state_d     = ST_CLEAR;
                end
            end
            ST_CLEAR: state_d = ST_PLAY;
            ST_PLAY: begin
                if (preempt) begin
                    active_id_d = pre_idx;
                    state_d     = ST_CLEAR;
                end else if (rd_tick_i) begin
                    // Byte is sampled before the reader advances its address.
                    if (rom_byte == TERM_CHAR) begin
                        state_d = ST_DONE;
                    end else begin
                        char_out_d   = rom_byte;
                        char_valid_d = 1'b1;
                        if (rd_done_i) begin
                            state_d = ST_DONE;
                        end
                    end
                end
            end
            ST_DONE: begin
                gap_cnt_d = '0;
                state_d   = ST_GAP;
            end
            ST_GAP: begin
                if (gap_cnt_q == GAP_LAST) begin
                    state_d = ST_IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Registered restart lines up exactly with the CLEAR state.
        rd_clr_n_d = (state_d != ST_CLEAR);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            pending_q    <= 4'b0000;
            active_id_q  <= 2'd0;
            char_out_q   <= 8'h00;
            char_valid_q <= 1'b0;
            rd_clr_n_q   <= 1'b1;
            gap_cnt_q    <= '0;
        end else begin
            state_q      <= state_d;
            pending_q    <= pending_d;
            active_id_q  <= active_id_d;
            char_out_q   <= char_out_d;
            char_valid_q <= char_valid_d;
            rd_clr_n_q   <= rd_clr_n_d;
            gap_cnt_q    <= gap_cnt_d;
        end
    end

    assign rd_en_o      = (state_q == ST_PLAY);
    assign busy_o       = (state_q == ST_CLEAR) || (state_q == ST_PLAY);
    assign rd_clr_n_o   = rd_clr_n_q;
    assign char_out_o   = char_out_q;
    assign char_valid_o = char_valid_q;
    assign active_id_o  = active_id_q;
    assign ack_o        = ack_w;

endmodule

// File: tb/tb_alarm_msg_scheduler.sv
// -----------------------------------------------------------------------------
// tb_alarm_msg_scheduler
// Drives alarm_msg_scheduler with a behavioural text reader (4-cycle tick,
// 256-byte ROM per colour, final address 254) and checks strobes, acks and
// CLEAR timing against an expected-message model derived from the ROM data.
// -----------------------------------------------------------------------------
module tb_alarm_msg_scheduler;

    localparam int GAP       = 12;
    localparam int LAST_ADDR = 254;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [3:0] req = 4'b0000;
    logic       rd_tick, rd_done;
    logic [7:0] rom_r, rom_b, rom_p, rom_y;
    logic       rd_en, rd_clr_n, char_valid, busy;
    logic [7:0] char_out;
    logic [1:0] active_id;
    logic [3:0] ack;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    alarm_msg_scheduler #(.GAP_CYCLES(GAP)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .req_i        (req),
        .rd_tick_i    (rd_tick),
        .rd_done_i    (rd_done),
        .rom_r_i      (rom_r),
        .rom_b_i      (rom_b),
        .rom_p_i      (rom_p),
        .rom_y_i      (rom_y),
        .rd_en_o      (rd_en),
        .rd_clr_n_o   (rd_clr_n),
        .char_out_o   (char_out),
        .char_valid_o (char_valid),
        .active_id_o  (active_id),
        .busy_o       (busy),
        .ack_o        (ack)
    );

    // ---------------- behavioural text reader ----------------
    logic [7:0] mem [4][256];
    logic [1:0] tmr;
    logic [7:0] addr;
    wire        rclr_n = reset_n & rd_clr_n;

    always @(posedge clk) begin
        if (!rclr_n) begin
            tmr  <= 2'd0;
            addr <= 8'd0;
        end else if (rd_en) begin
            if (tmr == 2'd3) begin
                tmr  <= 2'd0;
                addr <= addr + 8'd1;
            end else begin
                tmr <= tmr + 2'd1;
            end
        end
    end

    assign rd_tick = rd_en && (tmr == 2'd3);
    assign rd_done = (addr == 8'(LAST_ADDR));
    assign rom_r   = mem[0][addr];
    assign rom_b   = mem[1][addr];
    assign rom_p   = mem[2][addr];
    assign rom_y   = mem[3][addr];

    // ---------------- monitor ----------------
    int         cyc = 0;
    logic [7:0] s_char[$];
    logic [1:0] s_id[$];
    logic [3:0] a_val[$];
    int         a_cyc[$];
    int         c_cyc[$];
    logic [1:0] c_id[$];
    int         lat_err = 0;
    int         clr_err = 0;
    logic       prev_tick = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (char_valid) begin
            s_char.push_back(char_out);
            s_id.push_back(active_id);
            if (!prev_tick) lat_err <= lat_err + 1;
        end
        if (ack != 4'b0000) begin
            a_val.push_back(ack);
            a_cyc.push_back(cyc);
            $display("ack=%b id=%0d cycle=%0d", ack, active_id, cyc);
        end
        if (!rd_clr_n) begin
            if (!busy || rd_en) clr_err <= clr_err + 1;
            if (c_cyc.size() > 0 && c_cyc[c_cyc.size()-1] == cyc - 1) clr_err <= clr_err + 1;
            c_cyc.push_back(cyc);
            c_id.push_back(active_id);
        end
        if (rd_en && !busy) clr_err <= clr_err + 1;
        prev_tick <= rd_tick;
    end

    // ---------------- reference model ----------------
    logic [7:0] exp_char[$];
    logic [1:0] exp_id[$];
    logic [3:0] exp_ack[$];

    task automatic clear_exp();
        exp_char.delete();
        exp_id.delete();
        exp_ack.delete();
    endtask

    // A message is the ROM bytes from address 0 up to (not including) the
    // terminator, or up to and including the final reader address.
    task automatic add_exp(input int c);
        for (int a = 0; a < 256; a++) begin
            if (mem[c][a] == 8'h00) break;
            exp_char.push_back(mem[c][a]);
            exp_id.push_back(2'(c));
            if (a == LAST_ADDR) break;
        end
        exp_ack.push_back(4'(1 << c));
    endtask

    function automatic int char_diff(input int s0);
        int n = s_char.size() - s0;
        for (int i = 0; i < n && i < exp_char.size(); i++)
            if (s_char[s0+i] !== exp_char[i] || s_id[s0+i] !== exp_id[i]) return i;
        if (n != exp_char.size()) return (n < exp_char.size()) ? n : exp_char.size();
        return -1;
    endfunction

    function automatic int ack_diff(input int a0);
        int n = a_val.size() - a0;
        for (int i = 0; i < n && i < exp_ack.size(); i++)
            if (a_val[a0+i] !== exp_ack[i]) return i;
        if (n != exp_ack.size()) return (n < exp_ack.size()) ? n : exp_ack.size();
        return -1;
    endfunction

    task automatic set_msg(input int c, input int len);
        for (int a = 0; a < 256; a++) mem[c][a] = 8'h00;
        for (int a = 0; a < len; a++) mem[c][a] = 8'($urandom_range(1, 255));
    endtask

    task automatic pulse(input logic [3:0] m);
        @(negedge clk);
        req = m;
        @(negedge clk);
        req = 4'b0000;
    endtask

    task automatic wait_acks(input int n, input int budget, output bit to);
        to = 1'b1;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk);
            if (a_val.size() >= n) begin
                to = 1'b0;
                break;
            end
        end
        @(negedge clk);
    endtask

    task automatic settle();
        repeat (GAP + 4) @(negedge clk);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset_n = 1'b0;
        req     = 4'b0000;
        repeat (3) @(negedge clk);
        checks++; if (rd_en !== 1'b0)        begin errors++; $display("FAIL reset_rd_en: got %b want 0", rd_en); end
        checks++; if (rd_clr_n !== 1'b1)     begin errors++; $display("FAIL reset_rd_clr_n: got %b want 1", rd_clr_n); end
        checks++; if (char_out !== 8'h00)    begin errors++; $display("FAIL reset_char_out: got %h want 00", char_out); end
        checks++; if (char_valid !== 1'b0)   begin errors++; $display("FAIL reset_char_valid: got %b want 0", char_valid); end
        checks++; if (active_id !== 2'd0)    begin errors++; $display("FAIL reset_active_id: got %0d want 0", active_id); end
        checks++; if (busy !== 1'b0)         begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (ack !== 4'b0000)       begin errors++; $display("FAIL reset_ack: got %b want 0000", ack); end
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (busy !== 1'b0 || rd_en !== 1'b0) begin errors++; $display("FAIL idle_after_reset: busy=%b rd_en=%b want 0/0", busy, rd_en); end
    endtask

    task automatic test_sos();
        int s0 = s_char.size();
        int a0 = a_val.size();
        int c0 = c_cyc.size();
        int bad = 0;
        int d;
        bit to;
        for (int c = 0; c < 4; c++) begin
            for (int a = 0; a < 256; a++) mem[c][a] = 8'h00;
            mem[c][0] = "S"; mem[c][1] = "O"; mem[c][2] = "S";
        end
        clear_exp();
        add_exp(0);
        pulse(4'b0001);
        wait_acks(a0 + 1, 200, to);
        checks++; if (to) begin errors++; $display("FAIL sos_timeout: no ack within 200 cycles"); end
        d = char_diff(s0);
        checks++; if (d != -1) begin errors++; $display("FAIL sos_chars: first difference at %0d, got %0d chars want 3", d, s_char.size() - s0); end
        d = ack_diff(a0);
        checks++; if (d != -1) begin errors++; $display("FAIL sos_ack: difference at %0d, got %0d acks want 1 of 0001", d, a_val.size() - a0); end
        checks++; if (c_cyc.size() - c0 != 1 || (c_cyc.size() > c0 && c_id[c0] !== 2'd0))
            begin errors++; $display("FAIL sos_clear: got %0d CLEAR pulses want 1 with id 0", c_cyc.size() - c0); end
        repeat (GAP) begin
            if (rd_en !== 1'b0 || busy !== 1'b0) bad++;
            @(negedge clk);
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL sos_gap: %0d gap cycles with rd_en/busy high, want 0", bad); end
        settle();
    endtask

    task automatic test_two_req();
        int s0 = s_char.size();
        int a0 = a_val.size();
        int c0 = c_cyc.size();
        int d, gap;
        bit to;
        for (int c = 0; c < 4; c++) set_msg(c, 3 + c);
        clear_exp();
        add_exp(1);
        add_exp(3);
        pulse(4'b1010);
        wait_acks(a0 + 2, 400, to);
        checks++; if (to) begin errors++; $display("FAIL two_timeout: got %0d acks want 2", a_val.size() - a0); end
        d = ack_diff(a0);
        checks++; if (d != -1) begin errors++; $display("FAIL two_ack_order: difference at %0d, want 0010 then 1000", d); end
        d = char_diff(s0);
        checks++; if (d != -1) begin errors++; $display("FAIL two_chars: first difference at %0d, got %0d want %0d", d, s_char.size() - s0, exp_char.size()); end
        gap = (c_cyc.size() >= c0 + 2 && a_cyc.size() > a0) ? c_cyc[c0+1] - a_cyc[a0] : -1;
        checks++; if (gap != GAP + 2) begin errors++; $display("FAIL two_gap: ack to next CLEAR %0d cycles want %0d", gap, GAP + 2); end
        settle();
    endtask

    task automatic test_random();
        logic [3:0] m;
        int s0, a0, d, n;
        bit to;
        for (int it = 0; it < 4; it++) begin
            for (int c = 0; c < 4; c++) set_msg(c, $urandom_range(1, 6));
            m  = 4'($urandom_range(1, 15));
            s0 = s_char.size();
            a0 = a_val.size();
            clear_exp();
            n = 0;
            for (int c = 0; c < 4; c++) if (m[c]) begin add_exp(c); n++; end
            pulse(m);
            wait_acks(a0 + n, 800, to);
            checks++; if (to) begin errors++; $display("FAIL rand%0d_timeout: mask %b got %0d acks want %0d", it, m, a_val.size() - a0, n); end
            d = ack_diff(a0);
            checks++; if (d != -1) begin errors++; $display("FAIL rand%0d_ack: mask %b difference at ack %0d", it, m, d); end
            d = char_diff(s0);
            checks++; if (d != -1) begin errors++; $display("FAIL rand%0d_chars: mask %b first difference at %0d, got %0d want %0d", it, m, d, s_char.size() - s0, exp_char.size()); end
            settle();
        end
    endtask

    task automatic test_no_term();
        int s0 = s_char.size();
        int a0 = a_val.size();
        int d;
        bit to;
        for (int a = 0; a < 256; a++) mem[0][a] = 8'($urandom_range(1, 255));
        clear_exp();
        add_exp(0);
        pulse(4'b0001);
        wait_acks(a0 + 1, 2000, to);
        checks++; if (to) begin errors++; $display("FAIL noterm_timeout: no ack within 2000 cycles"); end
        checks++; if (s_char.size() - s0 != LAST_ADDR + 1) begin errors++; $display("FAIL noterm_count: got %0d chars want %0d", s_char.size() - s0, LAST_ADDR + 1); end
        d = char_diff(s0);
        checks++; if (d != -1) begin errors++; $display("FAIL noterm_chars: first difference at %0d", d); end
        d = ack_diff(a0);
        checks++; if (d != -1) begin errors++; $display("FAIL noterm_ack: difference at %0d, want one 0001", d); end
        settle();
    endtask

    task automatic test_preempt();
        int s0 = s_char.size();
        int a0 = a_val.size();
        int c0;
        int d, pulse_cyc, got_cyc;
        bit to;
        logic [1:0] got_id;
        set_msg(3, 10);
        set_msg(0, 3);
        pulse(4'b1000);
        to = 1'b1;
        for (int i = 0; i < 300; i++) begin
            @(posedge clk);
            if (s_char.size() >= s0 + 2) begin to = 1'b0; break; end
        end
        checks++; if (to) begin errors++; $display("FAIL pre_start: yellow produced %0d chars want >=2", s_char.size() - s0); end
        @(negedge clk);
        c0 = c_cyc.size();
        pulse_cyc = cyc;
        req = 4'b0001;
        @(negedge clk);
        req = 4'b0000;
        clear_exp();
`ifdef ALARM_PREEMPT_EN
        add_exp(0);
        add_exp(3);
        wait_acks(a0 + 2, 800, to);
        got_cyc = (c_cyc.size() > c0) ? c_cyc[c0] : -1;
        got_id  = (c_cyc.size() > c0) ? c_id[c0] : 2'd3;
        checks++; if (got_cyc != pulse_cyc + 2 || got_id !== 2'd0)
            begin errors++; $display("FAIL pre_clear: CLEAR at %0d id %0d want %0d id 0", got_cyc, got_id, pulse_cyc + 2); end
`else
        add_exp(3);
        add_exp(0);
        wait_acks(a0 + 2, 800, to);
        d = char_diff(s0);
        checks++; if (d != -1) begin errors++; $display("FAIL pre_chars: first difference at %0d, want full yellow then red", d); end
        got_cyc = (c_cyc.size() > c0 && a_cyc.size() > a0) ? c_cyc[c0] - a_cyc[a0] : -1;
        checks++; if (got_cyc != GAP + 2) begin errors++; $display("FAIL pre_clear: red CLEAR %0d cycles after yellow ack want %0d", got_cyc, GAP + 2); end
`endif
        checks++; if (to) begin errors++; $display("FAIL pre_timeout: got %0d acks want 2", a_val.size() - a0); end
        d = ack_diff(a0);
        checks++; if (d != -1) begin errors++; $display("FAIL pre_ack_order: difference at ack %0d", d); end
        settle();
    endtask

    task automatic test_reset_mid();
        int s0 = s_char.size();
        int a1, s1, c1;
        bit to;
        set_msg(1, 10);
        pulse(4'b0010);
        to = 1'b1;
        for (int i = 0; i < 300; i++) begin
            @(posedge clk);
            if (s_char.size() > s0) begin to = 1'b0; break; end
        end
        checks++; if (to) begin errors++; $display("FAIL rmid_start: no char before reset"); end
        @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        checks++; if (rd_en !== 1'b0)      begin errors++; $display("FAIL rmid_rd_en: got %b want 0", rd_en); end
        checks++; if (rd_clr_n !== 1'b1)   begin errors++; $display("FAIL rmid_rd_clr_n: got %b want 1", rd_clr_n); end
        checks++; if (char_out !== 8'h00)  begin errors++; $display("FAIL rmid_char_out: got %h want 00", char_out); end
        checks++; if (busy !== 1'b0)       begin errors++; $display("FAIL rmid_busy: got %b want 0", busy); end
        checks++; if (active_id !== 2'd0)  begin errors++; $display("FAIL rmid_active_id: got %0d want 0", active_id); end
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        a1 = a_val.size();
        s1 = s_char.size();
        c1 = c_cyc.size();
        repeat (GAP + 60) @(negedge clk);
        checks++; if (a_val.size() != a1 || s_char.size() != s1 || c_cyc.size() != c1)
            begin errors++; $display("FAIL rmid_quiet: after release got %0d acks %0d chars %0d clears want 0/0/0",
                                     a_val.size() - a1, s_char.size() - s1, c_cyc.size() - c1); end
    endtask

    task automatic test_held();
        int s0 = s_char.size();
        int a0 = a_val.size();
        int c0 = c_cyc.size();
        int d, gap;
        bit to;
        set_msg(0, 3);
        clear_exp();
        add_exp(0);
        add_exp(0);
        @(negedge clk);
        req = 4'b0001;
        wait_acks(a0 + 1, 200, to);
        req = 4'b0000;
        checks++; if (to) begin errors++; $display("FAIL held_first: no ack within 200 cycles"); end
        wait_acks(a0 + 2, 300, to);
        checks++; if (to) begin errors++; $display("FAIL held_replay: got %0d acks want 2", a_val.size() - a0); end
        gap = (c_cyc.size() >= c0 + 2 && a_cyc.size() > a0) ? c_cyc[c0+1] - a_cyc[a0] : -1;
        checks++; if (gap != GAP + 2) begin errors++; $display("FAIL held_gap: replay CLEAR %0d cycles after ack want %0d", gap, GAP + 2); end
        settle();
        settle();
        d = ack_diff(a0);
        checks++; if (d != -1) begin errors++; $display("FAIL held_ack: difference at %0d, got %0d acks want 2x 0001", d, a_val.size() - a0); end
        d = char_diff(s0);
        checks++; if (d != -1) begin errors++; $display("FAIL held_chars: first difference at %0d", d); end
    endtask

    task automatic test_protocol();
        checks++; if (lat_err != 0) begin errors++; $display("FAIL latency: %0d strobes not one cycle after a tick, want 0", lat_err); end
        checks++; if (clr_err != 0) begin errors++; $display("FAIL clear_shape: %0d bad CLEAR/PLAY cycles, want 0", clr_err); end
    endtask

    initial begin
        for (int c = 0; c < 4; c++)
            for (int a = 0; a < 256; a++) mem[c][a] = 8'h00;
        test_reset();
        test_sos();
        test_two_req();
        test_random();
        test_no_term();
        test_preempt();
        test_reset_mid();
        test_held();
        test_protocol();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
